// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART serial transmitter with one-entry holding buffer
//
// Purpose:
//   Serialises DATA_BITS-wide words as UART frames: start bit, data LSB
//   first, optional odd/even parity, then 1 or 2 stop bits. A one-entry
//   holding buffer lets the producer queue the next word while the current
//   frame shifts out, so consecutive frames leave with no idle gap.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_tx_valid   producer offers i_tx_byte this cycle
//   i_tx_byte    word to send, LSB first
//   o_tx_ready   holding buffer empty; a word can be accepted this cycle
//   o_tx_serial  serial line, idle high
//   o_tx_active  high while any frame bit is on the line
//   o_done       one-cycle pulse on the last cycle of each frame
//
// All outputs come straight from flops.
module uart_tx_frame #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  output logic                 o_tx_active,
  output logic                 o_done
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP  = (STOP_BITS == 2);
  localparam bit            HAS_PARITY = (PARITY != 0);
  localparam logic          ODD        = (PARITY == 1);

  generate
    if (CLK_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $fatal(1, "uart_tx_frame: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic [IW-1:0]          idx_q, idx_n;
  logic                   stop_q, stop_n;
  logic [DATA_BITS-1:0]   shift_q, shift_n;
  logic [DATA_BITS-1:0]   buf_q, buf_n;
  logic                   full_q, full_n;
  logic                   pend_q, pend_n;

  logic                   serial_n;
  logic                   active_n;
  logic                   done_n;
  logic                   ready_n;
  logic                   par_bit;
  logic                   accept;
  logic                   bit_end;

  assign accept  = i_tx_valid & o_tx_ready;
  assign bit_end = (cnt_q == LAST_CNT);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    stop_n   = stop_q;
    shift_n  = shift_q;
    buf_n    = buf_q;
    full_n   = full_q;
    pend_n   = pend_q;
    serial_n = 1'b1;
    par_bit  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_n = bit_end ? '0 : cnt_q + 1'b1;
    end

    // A word only bypasses the buffer when the shifter is free (clean IDLE);
    // everywhere else it parks in the holding buffer.
    if (accept && (state_q != S_IDLE || pend_q)) begin
      buf_n  = i_tx_byte;
      full_n = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // Word captured on the final stop edge of the previous frame.
          state_n = S_START;
          pend_n  = 1'b0;
        end else if (accept) begin
          shift_n = i_tx_byte;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_n   = '0;
            stop_n  = 1'b0;
            state_n = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          stop_n  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q != LAST_STOP) begin
            stop_n = 1'b1;
          end else begin
            stop_n = 1'b0;
            if (full_q) begin
              // Drain the buffer straight into the next frame: no idle gap.
              shift_n = buf_q;
              full_n  = 1'b0;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
              if (accept) begin
                shift_n = i_tx_byte;
                full_n  = 1'b0;
                pend_n  = 1'b1;
              end
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Output flops are loaded from the next-state view so the line changes
    // in the same cycle the state does.
    par_bit = (^shift_n) ^ ODD;
    unique case (state_n)
      S_IDLE:   serial_n = 1'b1;
      S_START:  serial_n = 1'b0;
      S_DATA:   serial_n = shift_n[idx_n];
      S_PARITY: serial_n = par_bit;
      S_STOP:   serial_n = 1'b1;
      default:  serial_n = 1'b1;
    endcase
    active_n = (state_n != S_IDLE);
    done_n   = (state_n == S_STOP) && (cnt_n == LAST_CNT) && (stop_n == LAST_STOP);
    ready_n  = ~full_n;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      buf_q       <= '0;
      full_q      <= 1'b0;
      pend_q      <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_ready  <= 1'b1;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      idx_q       <= idx_n;
      stop_q      <= stop_n;
      shift_q     <= shift_n;
      buf_q       <= buf_n;
      full_q      <= full_n;
      pend_q      <= pend_n;
      o_tx_serial <= serial_n;
      o_tx_active <= active_n;
      o_tx_ready  <= ready_n;
      o_done      <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame over five frame formats
module tb_uart_tx_frame;

  localparam int NI = 5;
  // inst0 8N1, inst1 8E1, inst2 8O1, inst3 7N2 (all 16 clk/bit), inst4 5N1 at 4 clk/bit
  localparam int CPB_T [NI] = '{16, 16, 16, 16, 4};
  localparam int DB_T  [NI] = '{8, 8, 8, 7, 5};
  localparam int PAR_T [NI] = '{0, 2, 1, 0, 0};
  localparam int SB_T  [NI] = '{1, 1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid [NI];
  logic [8:0] tx_byte  [NI];
  logic       tx_ready [NI];
  logic       serial   [NI];
  logic       active   [NI];
  logic       done     [NI];

  // Expected frames per instance: {parity bit, word}
  logic [9:0] exp_q [NI][$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int CPB = CPB_T[g];
    localparam int DB  = DB_T[g];
    localparam int PAR = PAR_T[g];
    localparam int SB  = SB_T[g];
    localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FL  = NB * CPB;

    uart_tx_frame #(
      .CLK_PER_BIT(CPB),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB)
    ) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_tx_valid (tx_valid[g]),
      .i_tx_byte  (tx_byte[g][DB-1:0]),
      .o_tx_ready (tx_ready[g]),
      .o_tx_serial(serial[g]),
      .o_tx_active(active[g]),
      .o_done     (done[g])
    );

    // Monitor: a falling line starts a frame; every cycle of it is checked
    // against the bit pattern built from the scoreboard entry.
    initial begin : mon
      logic [9:0] w;
      logic       eb [0:12];
      bit         have, bad, abort;
      int         bj;
      logic       bs, ba, bd, be, bde;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && serial[g] === 1'b0) begin
          have = (exp_q[g].size() != 0);
          w = '0;
          if (have) w = exp_q[g].pop_front();
          eb[0] = 1'b0;
          for (int i = 0; i < DB; i++) eb[1 + i] = w[i];
          if (PAR != 0) eb[1 + DB] = w[9];
          for (int s = 0; s < SB; s++) eb[NB - SB + s] = 1'b1;
          bad = 0; abort = 0; bj = -1;
          bs = 0; ba = 0; bd = 0; be = 0; bde = 0;
          for (int j = 0; j < FL; j++) begin
            if (j > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              abort = 1;
              break;
            end
            if (!bad && (serial[g] !== eb[j / CPB] || active[g] !== 1'b1 ||
                         done[g] !== (j == FL - 1))) begin
              bad = 1; bj = j;
              bs = serial[g]; ba = active[g]; bd = done[g];
              be = eb[j / CPB]; bde = (j == FL - 1);
            end
          end
          if (!abort) begin
            n_tests++;
            if (!have) begin
              n_fail++;
              $display("FAIL frame_inst%0d: got an unexpected frame on the line, required idle line", g);
            end else if (bad) begin
              n_fail++;
              $display("FAIL frame_inst%0d word 'h%0h: cycle %0d got serial=%b active=%b done=%b, required serial=%b active=1 done=%b",
                       g, w[8:0], bj, bs, ba, bd, be, bde);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, got, req);
    end
  endtask

  task automatic send(input int k, input logic [8:0] d, input logic p);
    int t;
    @(negedge clk);
    tx_byte[k]  = d;
    tx_valid[k] = 1'b1;
    t = 0;
    while (tx_ready[k] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready[k] !== 1'b1) begin
      chk($sformatf("send_timeout_inst%0d", k), 0, 1);
      tx_valid[k] = 1'b0;
      return;
    end
    exp_q[k].push_back({p, d});
    @(posedge clk);
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int start, output int cyc);
    cyc = start;
    while (done[k] !== 1'b1 && cyc < start + 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (done[k] !== 1'b1) chk($sformatf("done_timeout_inst%0d", k), 0, 1);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while ((exp_q[k].size() != 0 || active[k] !== 1'b0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("idle_timeout_inst%0d", k), int'(exp_q[k].size() == 0 && active[k] === 1'b0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      tx_valid[k] = 1'b0;
      tx_byte[k]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("reset_state_inst%0d", k),
          int'({serial[k], active[k], tx_ready[k], done[k]}), 'b1010);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, 0xA5 from IDLE
    send(0, 9'h0A5, 1'b0);
    chk("t1_start_latency", int'({serial[0], active[0], tx_ready[0]}), 'b011);
    wait_done(0, 1, cyc);
    chk("t1_done_cycle", cyc, 160);
    @(negedge clk);
    chk("t1_idle_after", int'({serial[0], active[0], done[0]}), 'b100);
    wait_idle(0);

    // 0x07: even parity bit 1, odd parity bit 0
    send(1, 9'h007, 1'b1);
    wait_done(1, 1, cyc);
    chk("t2_even_frame_len", cyc, 176);
    wait_idle(1);
    send(2, 9'h007, 1'b0);
    wait_done(2, 1, cyc);
    chk("t2_odd_frame_len", cyc, 176);
    wait_idle(2);

    // 7N2 back-to-back, third word held while the buffer is full
    send(3, 9'h07F, 1'b0);
    repeat (40) @(negedge clk);
    send(3, 9'h000, 1'b0);
    chk("t3_ready_drop", int'(tx_ready[3]), 0);
    fork
      send(3, 9'h055, 1'b0);
      begin
        wait_done(3, 0, cyc);
        @(negedge clk);
        chk("t3_b2b_start", int'({serial[3], active[3], done[3]}), 'b010);
      end
    join
    wait_idle(3);

    // Reset mid-DATA with a word buffered, then a fresh frame
    send(0, 9'h0C3, 1'b0);
    repeat (40) @(negedge clk);
    send(0, 9'h099, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_reset_immediate", int'({serial[0], tx_ready[0], active[0]}), 'b110);
    exp_q[0].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(0, 9'h03C, 1'b0);
    wait_done(0, 1, cyc);
    chk("t5_fresh_frame_len", cyc, 160);
    wait_idle(0);

    // 5N1 at 4 clk/bit, upper byte bits set but unconnected
    send(4, 9'h0FF, 1'b0);
    wait_done(4, 1, cyc);
    chk("t6_frame_len", cyc, 28);
    wait_idle(4);

    repeat (40) @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("tail_quiet_inst%0d", k),
          int'({serial[k], active[k], tx_ready[k]}), 'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
